// File: rtl/tmc_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// tmc_mem_arb_pkg
// Shared definitions for the two-requester on-chip memory arbiter.
//   - Default geometry: word-address width, data width, byte-enable width and
//     number of implemented memory words.
//   - Requester index constants, used to pick bits out of req/gnt vectors.
//   - Priority pointer encoding for the round-robin arbiter.
// -----------------------------------------------------------------------------
package tmc_mem_arb_pkg;

  localparam int TMC_ADDR_W = 14;
  localparam int TMC_DATA_W = 32;
  localparam int TMC_BE_W   = TMC_DATA_W / 8;
  localparam int TMC_DEPTH  = 9000;

  // Requester indices into req/gnt/readdatavalid vectors.
  localparam int REQ_M0  = 0;
  localparam int REQ_M1  = 1;
  localparam int NUM_REQ = 2;

  // Which requester wins when both request in the same cycle.
  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_e;

endpackage : tmc_mem_arb_pkg

// File: rtl/tmc_rr_arb2.sv
// -----------------------------------------------------------------------------
// tmc_rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the current
// requests and the priority pointer; the pointer moves to the other requester
// only when a grant is actually issued.
//
// Ports
//   clk       in   1  clock
//   reset     in   1  synchronous active-high reset; pointer favours M0 next
//   i_req     in   2  request vector, bit REQ_M0 / REQ_M1
//   i_accept  in   1  grants may be issued this cycle (low = freeze)
//   o_gnt     out  2  one-hot grant, or zero when nothing is granted
// -----------------------------------------------------------------------------
module tmc_rr_arb2
  import tmc_mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_gnt
);

  prio_e              r_prio;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;

  // A frozen arbiter sees no requests at all, so it can neither grant nor
  // move its pointer.
  assign w_req = i_accept ? i_req : '0;

  // NOTE: every output of an always_comb gets a default on entry; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    w_gnt = '0;
    case (w_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = (r_prio == PRIO_M1) ? 2'b10 : 2'b01;
      default: w_gnt = '0;
    endcase
  end

  assign o_gnt = w_gnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= PRIO_M0;
    end else if (w_gnt != '0) begin
      // The requester just served drops to lowest priority.
      r_prio <= w_gnt[REQ_M1] ? PRIO_M0 : PRIO_M1;
    end
  end

endmodule : tmc_rr_arb2

// File: rtl/tmc_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tmc_onchip_mem_arbiter
// Shares one single-port on-chip RAM between two Avalon-MM style requesters.
// One transfer is accepted per cycle (round-robin on contention), the memory
// port is driven combinationally from the granted requester, and read data
// returns with a fixed latency of one cycle to the requester that issued it.
// Addresses at or beyond DEPTH are accepted but never reach the RAM: reads
// return zero, writes are dropped, and a sticky range_err flag is raised.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   reset_req             memory freeze: no grants, RAM clock enable low
//   mN_address/byteenable/read/write/writedata   requester N command (N=0,1)
//   mN_waitrequest        high = command not accepted this cycle
//   mN_readdata/readdatavalid                    requester N read return
//   mem_address/byteenable/chipselect/write/writedata/clken  RAM command
//   mem_readdata          RAM output, valid one cycle after the read address
//   range_err, err_clr    sticky out-of-range flag and its clear
// -----------------------------------------------------------------------------
module tmc_onchip_mem_arbiter
  import tmc_mem_arb_pkg::*;
#(
  parameter  int ADDR_W = TMC_ADDR_W,
  parameter  int DATA_W = TMC_DATA_W,
  parameter  int DEPTH  = TMC_DEPTH,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic              range_err,
  input  logic              err_clr
);

  // ---------------------------------------------------------------------------
  // Request and grant
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_block;
  logic               w_accept;

  assign w_req[REQ_M0] = m0_read | m0_write;
  assign w_req[REQ_M1] = m1_read | m1_write;

  // Nothing may be accepted during reset or while the memory is frozen.
  assign w_block  = reset | reset_req;
  assign w_accept = |w_gnt;

  tmc_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_accept (~w_block),
    .o_gnt    (w_gnt)
  );

  // ---------------------------------------------------------------------------
  // Granted-command mux. Everything is zero when no transfer is accepted so the
  // RAM port idles at a clean all-zero command.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_write;
  logic              w_in_range;
  logic              w_cs;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    if (w_gnt[REQ_M1]) begin
      w_sel_addr  = m1_address;
      w_sel_be    = m1_byteenable;
      w_sel_wdata = m1_writedata;
      w_sel_write = m1_write;      // read+write together counts as a write
    end else if (w_gnt[REQ_M0]) begin
      w_sel_addr  = m0_address;
      w_sel_be    = m0_byteenable;
      w_sel_wdata = m0_writedata;
      w_sel_write = m0_write;
    end
  end

  // Compare at 32 bits so a DEPTH that does not fit in ADDR_W still works.
  assign w_in_range = (32'(w_sel_addr) < 32'(DEPTH));
  assign w_cs       = w_accept & w_in_range;

  assign mem_address    = w_sel_addr;
  assign mem_byteenable = w_sel_be;
  assign mem_writedata  = w_sel_wdata;
  assign mem_chipselect = w_cs;
  assign mem_write      = w_cs & w_sel_write;
  assign mem_clken      = ~reset_req;

  // ---------------------------------------------------------------------------
  // Waitrequest: high for a requester that asks but is not granted, and for
  // everyone during reset. An idle requester is never stalled otherwise.
  // ---------------------------------------------------------------------------
  assign m0_waitrequest = reset | (w_req[REQ_M0] & ~w_gnt[REQ_M0]);
  assign m1_waitrequest = reset | (w_req[REQ_M1] & ~w_gnt[REQ_M1]);

  // ---------------------------------------------------------------------------
  // Read-return pipeline and sticky range error.
  // r_rdv[N]  : requester N had a read accepted last cycle.
  // r_rd_oor  : that read was out of range, so its data must be forced to 0.
  // reset_req does not touch this pipeline, so a read accepted just before a
  // freeze still returns its data (the RAM captured it with clken high).
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] r_rdv;
  logic               r_rd_oor;
  logic               r_range_err;
  logic               w_err_set;
  logic [NUM_REQ-1:0] w_rdv_out;

  assign w_err_set = w_accept & ~w_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdv       <= '0;
      r_rd_oor    <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_rdv    <= w_gnt & {NUM_REQ{~w_sel_write}};
      r_rd_oor <= w_err_set;
      // Set takes priority over a simultaneous clear.
      if (w_err_set) begin
        r_range_err <= 1'b1;
      end else if (err_clr) begin
        r_range_err <= 1'b0;
      end
    end
  end

  // Reset is synchronous, so a valid registered just before reset would still
  // be visible in the first reset cycle; mask it so reset cancels it outright.
  assign w_rdv_out = reset ? '0 : r_rdv;

  assign m0_readdatavalid = w_rdv_out[REQ_M0];
  assign m1_readdatavalid = w_rdv_out[REQ_M1];

  assign m0_readdata = (w_rdv_out[REQ_M0] && !r_rd_oor) ? mem_readdata : '0;
  assign m1_readdata = (w_rdv_out[REQ_M1] && !r_rd_oor) ? mem_readdata : '0;

  assign range_err = r_range_err;

endmodule : tmc_onchip_mem_arbiter

// File: tb/tb_tmc_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tmc_onchip_mem_arbiter
// Directed bench for the two-requester memory arbiter. A behavioural
// single-port RAM (read latency 1, byte enables, clock enable) sits on the
// memory port; every RAM word w is loaded with 0x1234_0000 + w on reset.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_tmc_onchip_mem_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 9000;

  logic          clk = 1'b0;
  logic          reset;
  logic          reset_req;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          range_err;
  logic          err_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tmc_onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .reset_req        (reset_req),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .range_err        (range_err),
    .err_clr          (err_clr)
  );

  // Behavioural single-port RAM, read-first, one cycle read latency.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] ram_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h1234_0000 + DW'(i);
      ram_q <= '0;
    end else if (mem_clken && mem_chipselect && (32'(mem_address) < DEPTH)) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_q <= ram[mem_address];
    end
  end

  assign mem_readdata = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, '0);
  endtask

  int g0 = 0;
  int g1 = 0;

  initial begin
    reset = 1'b1; reset_req = 1'b0; err_clr = 1'b0;
    idle();

    // ---- Reset state, m0 requesting during reset ----
    cyc(); drive0(1'b1, 1'b0, 14'd5, 4'hF, '0); #1;
    check("rst_m0_wait",  m0_waitrequest,   1'b1);
    check("rst_m1_wait",  m1_waitrequest,   1'b1);
    check("rst_cs",       mem_chipselect,   1'b0);
    check("rst_wr",       mem_write,        1'b0);
    check("rst_m0_rdv",   m0_readdatavalid, 1'b0);
    check("rst_m0_rdata", m0_readdata,      32'h0);
    check("rst_rerr",     range_err,        1'b0);

    // ---- Both read word 5 right after reset: m0 first, then m1 ----
    cyc(); reset = 1'b0;
    drive0(1'b1, 1'b0, 14'd5, 4'hF, '0); drive1(1'b1, 1'b0, 14'd5, 4'hF, '0); #1;
    check("rr_c1_m0_wait", m0_waitrequest, 1'b0);
    check("rr_c1_m1_wait", m1_waitrequest, 1'b1);
    check("rr_c1_cs",      mem_chipselect, 1'b1);
    check("rr_c1_addr",    mem_address,    14'd5);
    check("rr_c1_clken",   mem_clken,      1'b1);
    cyc(); drive0(1'b0, 1'b0, '0, '0, '0); #1;
    check("rr_c2_m1_wait", m1_waitrequest,   1'b0);
    check("rr_c2_m0_wait", m0_waitrequest,   1'b0);
    check("rr_c2_m0_rdv",  m0_readdatavalid, 1'b1);
    check("rr_c2_m0_data", m0_readdata,      32'h1234_0005);
    check("rr_c2_m1_rdv",  m1_readdatavalid, 1'b0);
    check("rr_c2_m1_data", m1_readdata,      32'h0);
    cyc(); idle(); #1;
    check("rr_c3_m1_rdv",  m1_readdatavalid, 1'b1);
    check("rr_c3_m1_data", m1_readdata,      32'h1234_0005);
    check("rr_c3_m0_rdv",  m0_readdatavalid, 1'b0);
    check("rr_c3_cs",      mem_chipselect,   1'b0);
    check("rr_c3_addr",    mem_address,      14'd0);

    // ---- Partial write then read-after-write from the other requester ----
    cyc(); drive0(1'b0, 1'b1, 14'd100, 4'h3, 32'hDEAD_BEEF); #1;
    check("wr_m0_wait", m0_waitrequest, 1'b0);
    check("wr_cs",      mem_chipselect, 1'b1);
    check("wr_write",   mem_write,      1'b1);
    check("wr_be",      mem_byteenable, 4'h3);
    check("wr_wdata",   mem_writedata,  32'hDEAD_BEEF);
    cyc(); idle(); drive1(1'b1, 1'b0, 14'd100, 4'hF, '0); #1;
    check("raw_m1_wait", m1_waitrequest,   1'b0);
    check("raw_write",   mem_write,        1'b0);
    check("wr_no_rdv",   m0_readdatavalid, 1'b0);
    cyc(); idle(); #1;
    check("raw_m1_rdv",  m1_readdatavalid, 1'b1);
    check("raw_m1_data", m1_readdata,      32'h1234_BEEF);

    // ---- Continuous contention: strict alternation, m0 first ----
    for (int k = 0; k < 10; k++) begin
      cyc(); drive0(1'b1, 1'b0, 14'd1, 4'hF, '0); drive1(1'b1, 1'b0, 14'd2, 4'hF, '0); #1;
      check($sformatf("alt%0d_m0_wait", k), m0_waitrequest, (k % 2) == 1);
      check($sformatf("alt%0d_m1_wait", k), m1_waitrequest, (k % 2) == 0);
      check($sformatf("alt%0d_cs", k),      mem_chipselect, 1'b1);
      if (k > 0) begin
        check($sformatf("alt%0d_m0_rdv", k), m0_readdatavalid, (k % 2) == 1);
        check($sformatf("alt%0d_m1_rdv", k), m1_readdatavalid, (k % 2) == 0);
        check($sformatf("alt%0d_rdata", k),
              (k % 2) == 1 ? m0_readdata : m1_readdata,
              (k % 2) == 1 ? 32'h1234_0001 : 32'h1234_0002);
      end
      if (!m0_waitrequest) g0++;
      if (!m1_waitrequest) g1++;
    end
    check("alt_grants_m0", g0, 5);
    check("alt_grants_m1", g1, 5);
    cyc(); idle(); #1;
    check("alt_last_m1_rdv",  m1_readdatavalid, 1'b1);
    check("alt_last_m1_data", m1_readdata,      32'h1234_0002);

    // ---- Out-of-range read, then clear of the sticky flag ----
    cyc(); drive0(1'b1, 1'b0, 14'd9000, 4'hF, '0); #1;
    check("oor_m0_wait", m0_waitrequest, 1'b0);
    check("oor_cs",      mem_chipselect, 1'b0);
    check("oor_rerr_c0", range_err,      1'b0);
    cyc(); idle(); #1;
    check("oor_m0_rdv",  m0_readdatavalid, 1'b1);
    check("oor_m0_data", m0_readdata,      32'h0);
    check("oor_rerr_c1", range_err,        1'b1);
    cyc(); err_clr = 1'b1; #1;
    check("clr_pending", range_err, 1'b1);
    cyc(); err_clr = 1'b0; #1;
    check("clr_done",    range_err, 1'b0);

    // ---- Memory freeze for 3 cycles while m1 reads continuously ----
    cyc(); drive1(1'b1, 1'b0, 14'd7, 4'hF, '0); #1;
    check("frz_pre_m1_wait", m1_waitrequest, 1'b0);
    check("frz_pre_cs",      mem_chipselect, 1'b1);
    for (int r = 0; r < 3; r++) begin
      cyc(); reset_req = 1'b1; #1;
      check($sformatf("frz%0d_m1_wait", r), m1_waitrequest,   1'b1);
      check($sformatf("frz%0d_m0_wait", r), m0_waitrequest,   1'b0);
      check($sformatf("frz%0d_clken", r),   mem_clken,        1'b0);
      check($sformatf("frz%0d_cs", r),      mem_chipselect,   1'b0);
      check($sformatf("frz%0d_m1_rdv", r),  m1_readdatavalid, r == 0);
      if (r == 0) check("frz_owed_data", m1_readdata, 32'h1234_0007);
    end
    cyc(); reset_req = 1'b0; #1;
    check("frz_post_m1_wait", m1_waitrequest,   1'b0);
    check("frz_post_clken",   mem_clken,        1'b1);
    check("frz_post_cs",      mem_chipselect,   1'b1);
    check("frz_post_addr",    mem_address,      14'd7);
    check("frz_post_m1_rdv",  m1_readdatavalid, 1'b0);
    cyc(); idle(); #1;
    check("frz_ret_m1_rdv",   m1_readdatavalid, 1'b1);
    check("frz_ret_m1_data",  m1_readdata,      32'h1234_0007);

    // ---- Out-of-range write with simultaneous clear: set wins, write dropped ----
    cyc(); drive1(1'b0, 1'b1, 14'd9001, 4'hF, 32'hCAFE_F00D); err_clr = 1'b1; #1;
    check("oorw_m1_wait", m1_waitrequest, 1'b0);
    check("oorw_cs",      mem_chipselect, 1'b0);
    check("oorw_write",   mem_write,      1'b0);
    cyc(); idle(); err_clr = 1'b0; #1;
    check("oorw_rerr",    range_err,        1'b1);
    check("oorw_no_rdv",  m1_readdatavalid, 1'b0);

    // ---- Read and write both high is a write ----
    cyc(); drive0(1'b1, 1'b1, 14'd200, 4'hF, 32'h1122_3344); #1;
    check("rw_write", mem_write, 1'b1);
    cyc(); drive0(1'b1, 1'b0, 14'd200, 4'hF, '0); #1;
    check("rw_no_rdv", m0_readdatavalid, 1'b0);
    cyc(); idle(); #1;
    check("rw_rd_rdv",  m0_readdatavalid, 1'b1);
    check("rw_rd_data", m0_readdata,      32'h1122_3344);

    // ---- Reset right after an accepted read: valid cancelled ----
    cyc(); drive0(1'b1, 1'b0, 14'd5, 4'hF, '0); #1;
    check("rra_m0_wait", m0_waitrequest, 1'b0);
    cyc(); reset = 1'b1; drive1(1'b1, 1'b0, 14'd6, 4'hF, '0); #1;
    check("rra_r0_m0_rdv",  m0_readdatavalid, 1'b0);
    check("rra_r0_m0_data", m0_readdata,      32'h0);
    check("rra_r0_m0_wait", m0_waitrequest,   1'b1);
    check("rra_r0_m1_wait", m1_waitrequest,   1'b1);
    check("rra_r0_cs",      mem_chipselect,   1'b0);
    cyc(); #1;
    check("rra_r1_m0_wait", m0_waitrequest,   1'b1);
    check("rra_r1_m0_rdv",  m0_readdatavalid, 1'b0);
    check("rra_r1_rerr",    range_err,        1'b0);
    // Pointer favoured m1 before reset; reset must return it to m0.
    cyc(); reset = 1'b0; #1;
    check("rra_post_m0_wait", m0_waitrequest, 1'b0);
    check("rra_post_m1_wait", m1_waitrequest, 1'b1);
    check("rra_post_addr",    mem_address,    14'd5);
    cyc(); drive0(1'b0, 1'b0, '0, '0, '0); #1;
    check("rra_m0_rdv",  m0_readdatavalid, 1'b1);
    check("rra_m0_data", m0_readdata,      32'h1234_0005);
    check("rra_m1_wait", m1_waitrequest,   1'b0);
    cyc(); idle(); #1;
    check("rra_m1_rdv",  m1_readdatavalid, 1'b1);
    check("rra_m1_data", m1_readdata,      32'h1234_0006);
    check("rra_idle_cs", mem_chipselect,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_tmc_onchip_mem_arbiter
